// File: rtl/instr_encoder.sv
// Encodes R/I/U field bundles into 32-bit instruction words and assigns each
// word a sequential instruction-memory address through a one-entry output stage.
module instr_encoder #(
  parameter int IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_fmt,
  input  logic [6:0]         in_opcode,
  input  logic [6:0]         in_funct7,
  input  logic [2:0]         in_funct3,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [19:0]        in_imm,
  input  logic               addr_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [IMEM_AW-1:0] out_addr,
  output logic               err,
  output logic [7:0]         err_cnt,
  output logic               wrapped
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t             state, state_nxt;
  logic [IMEM_AW-1:0] cnt;
  logic               legal;
  logic [31:0]        enc;
  logic               accept;
  logic               take;
  logic               reject;

  always_comb begin
    legal = 1'b0;
    enc   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    case (in_fmt)
      2'b00: legal = (in_opcode == OP_REG);
      2'b01: begin
        legal = (in_opcode == OP_IMM);
        enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      2'b10: begin
        legal = (in_opcode == OP_LUI) || (in_opcode == OP_AUIPC);
        enc   = {in_imm, in_rd, in_opcode};
      end
      default: legal = 1'b0;
    endcase
  end

  // Output process: in_ready looks through a draining word so a new bundle
  // can replace it in the same cycle.
  always_comb begin
    out_valid = (state == FULL);
    in_ready  = !rst && (!out_valid || out_ready);
  end

  assign accept = in_valid && in_ready;
  assign take   = accept && legal;
  assign reject = accept && !legal;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (take) state_nxt = FULL;
      FULL:  if (take) state_nxt = FULL;
             else if (out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr <= '0;
      out_addr  <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      wrapped   <= 1'b0;
    end else begin
      err <= reject;
      if (reject && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;
      if (take) begin
        out_instr <= enc;
        out_addr  <= addr_clr ? '0 : cnt;
        cnt       <= addr_clr ? IMEM_AW'(1) : cnt + IMEM_AW'(1);
        if (!addr_clr && (cnt == '1)) wrapped <= 1'b1;
      end else if (addr_clr) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vector table, hand-written corner sequences
// and a randomized run, all checked against a spec-level reference model.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, addr_clr, out_valid, out_ready;
  logic [1:0]    fmt;
  logic [6:0]    opc, f7;
  logic [2:0]    f3;
  logic [4:0]    rd, rs1, rs2;
  logic [19:0]   imm;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err, wrapped;
  logic [7:0]    err_cnt;

  int nchk = 0;
  int nerr = 0;

  instr_encoder #(.IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(fmt), .in_opcode(opc), .in_funct7(f7), .in_funct3(f3),
    .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
    .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err),
    .err_cnt(err_cnt), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model state
  bit          m_valid, m_wrap, m_err;
  int unsigned m_instr, m_addr, m_cnt, m_errcnt;

  function automatic bit is_legal(input int unsigned f, input int unsigned o);
    return (f == 0 && o == 'h33) || (f == 1 && o == 'h13) ||
           (f == 2 && (o == 'h37 || o == 'h17));
  endfunction

  function automatic int unsigned encode(input int unsigned f, o, fn7, fn3,
                                         d, s1, s2, im);
    if (f == 1) return ((im % 4096) << 20) + (s1 << 15) + (fn3 << 12) + (d << 7) + o;
    if (f == 2) return (im << 12) + (d << 7) + o;
    return (fn7 << 25) + (s2 << 20) + (s1 << 15) + (fn3 << 12) + (d << 7) + o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rdy, acc, lg;
    if (rst) begin
      m_valid = 0; m_instr = 0; m_addr = 0; m_cnt = 0;
      m_err = 0; m_errcnt = 0; m_wrap = 0;
      return;
    end
    rdy = !m_valid || out_ready;
    acc = in_valid && rdy;
    lg  = is_legal(fmt, opc);
    if (acc && lg) begin
      m_instr = encode(fmt, opc, f7, f3, rd, rs1, rs2, imm);
      m_addr  = addr_clr ? 0 : m_cnt;
      m_cnt   = m_addr + 1;
      if (m_cnt == (1 << AW)) begin
        m_cnt  = 0;
        m_wrap = 1;
      end
      m_valid = 1;
    end else begin
      if (out_ready) m_valid = 0;
      if (addr_clr) m_cnt = 0;
    end
    m_err = acc && !lg;
    if (m_err && m_errcnt < 255) m_errcnt++;
  endtask

  // One clock: check in_ready against the model, advance both, compare outputs.
  task automatic tick();
    #1;
    chk("in_ready", 32'(in_ready), 32'(!rst && (!m_valid || out_ready)));
    model_step();
    @(posedge clk);
    #1;
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    chk("m_out_instr", out_instr, m_instr);
    chk("m_out_addr", 32'(out_addr), m_addr);
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_err_cnt", 32'(err_cnt), m_errcnt);
    chk("m_wrapped", 32'(wrapped), 32'(m_wrap));
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; addr_clr = 0; out_ready = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic setb(input logic [1:0] f, input logic [6:0] o, input logic [6:0] a7,
                      input logic [2:0] a3, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [19:0] im);
    fmt = f; opc = o; f7 = a7; f3 = a3; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1;
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [19:0] imm;
    logic        legal;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int eaddr, ecnt;
    logic [31:0] w;

    vecs[0] = '{2'b00, 7'h33, 7'h00, 3'd0, 5'd3, 5'd1, 5'd2, 20'h00000, 1'b1, 32'h002081B3};
    vecs[1] = '{2'b01, 7'h13, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 20'h00FFF, 1'b1, 32'hFFF00293};
    vecs[2] = '{2'b10, 7'h37, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 20'h12345, 1'b1, 32'h123450B7};
    vecs[3] = '{2'b00, 7'h13, 7'h00, 3'd0, 5'd1, 5'd1, 5'd1, 20'h00000, 1'b0, 32'h0};
    vecs[4] = '{2'b10, 7'h17, 7'h00, 3'd0, 5'd2, 5'd0, 5'd0, 20'hABCDE, 1'b1, 32'hABCDE117};
    vecs[5] = '{2'b00, 7'h33, 7'h20, 3'd0, 5'd6, 5'd4, 5'd5, 20'h00000, 1'b1, 32'h40520333};
    vecs[6] = '{2'b11, 7'h33, 7'h00, 3'd0, 5'd1, 5'd1, 5'd1, 20'h00000, 1'b0, 32'h0};
    vecs[7] = '{2'b01, 7'h13, 7'h00, 3'd7, 5'd1, 5'd2, 5'd0, 20'hFF123, 1'b1, 32'h12317093};
    vecs[8] = '{2'b01, 7'h33, 7'h00, 3'd0, 5'd1, 5'd1, 5'd1, 20'h00000, 1'b0, 32'h0};
    vecs[9] = '{2'b10, 7'h33, 7'h00, 3'd0, 5'd1, 5'd1, 5'd1, 20'h00000, 1'b0, 32'h0};

    setb(2'b00, 7'h33, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 20'h0);
    rst = 1; in_valid = 1; addr_clr = 0; out_ready = 1;
    #1;
    chk("in_ready_during_rst", 32'(in_ready), 32'd0);
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);

    // Vector table
    eaddr = 0; ecnt = 0;
    foreach (vecs[i]) begin
      setb(vecs[i].fmt, vecs[i].opc, vecs[i].f7, vecs[i].f3, vecs[i].rd,
           vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      out_ready = 1;
      tick();
      in_valid = 0;
      if (vecs[i].legal) begin
        chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
        chk($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(eaddr));
        chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
        eaddr = (eaddr + 1) % (1 << AW);
      end else begin
        ecnt++;
        chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd0);
        chk($sformatf("vec%0d_err", i), 32'(err), 32'd1);
        chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(ecnt));
      end
      tick();
      chk($sformatf("vec%0d_err_gone", i), 32'(err), 32'd0);
      chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end
    chk("table_wrapped", 32'(wrapped), 32'd1);
    chk("table_err_cnt", 32'(err_cnt), 32'd4);

    // Backpressure: held word stable, pass-through when downstream drains
    do_reset();
    setb(2'b00, 7'h33, 7'h00, 3'd0, 5'd3, 5'd1, 5'd2, 20'h0);
    out_ready = 0;
    tick();
    setb(2'b01, 7'h13, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 20'h00FFF);
    repeat (3) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_instr_held", out_instr, 32'h002081B3);
      chk("bp_addr_held", 32'(out_addr), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
    chk("bp_new_instr", out_instr, 32'hFFF00293);
    chk("bp_new_addr", 32'(out_addr), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Illegal bundle does not advance the address
    do_reset();
    setb(2'b00, 7'h13, 7'h00, 3'd0, 5'd1, 5'd1, 5'd1, 20'h0);
    tick();
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_err_cnt", 32'(err_cnt), 32'd1);
    setb(2'b10, 7'h37, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 20'h12345);
    tick();
    in_valid = 0;
    chk("ill_err_pulse_end", 32'(err), 32'd0);
    chk("ill_next_addr", 32'(out_addr), 32'd0);
    chk("ill_next_instr", out_instr, 32'h123450B7);

    // Wrap and addr_clr
    do_reset();
    for (int unsigned k = 0; k < 5; k++) begin
      setb(2'b10, 7'h37, 7'h00, 3'd0, 5'(k), 5'd0, 5'd0, 20'(k));
      tick();
      chk($sformatf("wrap_addr%0d", k), 32'(out_addr), 32'(k % 4));
      chk($sformatf("wrap_flag%0d", k), 32'(wrapped), 32'(k >= 3));
    end
    addr_clr = 1;
    tick();
    addr_clr = 0;
    chk("clr_addr", 32'(out_addr), 32'd0);
    chk("clr_wrapped_kept", 32'(wrapped), 32'd1);
    tick();
    in_valid = 0;
    chk("clr_next_addr", 32'(out_addr), 32'd1);
    tick();

    // Reset while FULL discards the word
    do_reset();
    setb(2'b10, 7'h37, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 20'h12345);
    out_ready = 0;
    tick();
    chk("rf_full", 32'(out_valid), 32'd1);
    rst = 1; out_ready = 1; in_valid = 0;
    tick();
    rst = 0;
    chk("rf_valid", 32'(out_valid), 32'd0);
    chk("rf_instr", out_instr, 32'd0);

    // err_cnt saturation
    setb(2'b11, 7'h33, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 20'h0);
    repeat (260) tick();
    in_valid = 0;
    tick();
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    chk("sat_err", 32'(err), 32'd0);

    // Randomized run against the model
    do_reset();
    for (int unsigned n = 0; n < 3000; n++) begin
      w = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      addr_clr  = ($urandom_range(0, 15) == 0);
      in_valid  = w[0] | w[1];
      out_ready = w[2] | w[3];
      fmt       = w[5:4];
      case ($urandom_range(0, 4))
        0: opc = 7'h33;
        1: opc = 7'h13;
        2: opc = 7'h37;
        3: opc = 7'h17;
        default: opc = 7'($urandom);
      endcase
      w   = $urandom;
      f7  = w[6:0]; f3 = w[9:7]; rd = w[14:10]; rs1 = w[19:15]; rs2 = w[24:20];
      imm = 20'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter IMEM_AW, default 6: width of the instruction-memory word address.
REQ-002 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  in  1  synchronous, active-high reset.
REQ-004 Port in_valid  in  1  field bundle present.
REQ-005 Port in_ready  out  1  block can accept the bundle this cycle.
REQ-006 Port in_fmt  in  2  format: 00 R, 01 I, 10 U, 11 reserved.
REQ-007 Port in_opcode  in  7  major opcode.
REQ-008 Port in_funct7  in  7  R-type funct7.
REQ-009 Port in_funct3  in  3  R/I-type funct3.
REQ-010 Port in_rd / in_rs1 / in_rs2  in  5 each  register indices.
REQ-011 Port in_imm  in  20  immediate; I uses [11:0], U uses [19:0].
REQ-012 Port addr_clr  in  1  restart write address at 0.
REQ-013 Port out_valid  out  1  encoded word held.
REQ-014 Port out_ready  in  1  downstream (imem writer) accepts word.
REQ-015 Port out_instr  out  32  encoded instruction word.
REQ-016 Port out_addr  out  IMEM_AW  word address for out_instr.
REQ-017 Port err  out  1  one-cycle pulse on rejected bundle.
REQ-018 Port err_cnt  out  8  saturating count of rejected bundles.
REQ-019 Port wrapped  out  1  sticky: address counter has wrapped.

Function
REQ-020 Output stage is one register, states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-021 in_ready = !out_valid || out_ready (combinational; pass-through on simultaneous drain and fill).
REQ-022 Accept = in_valid && in_ready; accepted legal bundle appears on out_instr with out_valid=1 on the next cycle (latency 1).
REQ-023 Transitions: EMPTY->FULL on legal accept; FULL->EMPTY on out_ready with no legal accept; FULL->FULL on out_ready with legal accept (new word) or on !out_ready (hold).
REQ-024 While FULL and out_ready=0, out_instr and out_addr are held stable.
REQ-025 R encoding: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-026 I encoding: {imm[11:0], rs1, funct3, rd, opcode}; imm[19:12] ignored.
REQ-027 U encoding: {imm[19:0], rd, opcode}.
REQ-028 Legal iff (fmt=00, opcode=0110011) or (fmt=01, opcode=0010011) or (fmt=10, opcode=0110111 or 0010111).
REQ-029 Illegal accepted bundle: consumed (in_ready honoured), no output produced, output state unchanged, err=1 for exactly the next cycle, err_cnt +1 saturating at 255.
REQ-030 Address counter: each legal accept assigns the current counter value as that word's out_addr, then counter +1 modulo 2^IMEM_AW.
REQ-031 Counter step from 2^IMEM_AW-1 to 0 sets wrapped=1; wrapped stays 1 until reset.
REQ-032 addr_clr has priority: a word accepted in the addr_clr cycle gets address 0 and counter becomes 1; with no accept, counter becomes 0.
REQ-033 addr_clr does not disturb a held FULL word, err_cnt or wrapped.
REQ-034 Illegal bundles do not advance the counter.

Reset
REQ-035 rst dominates all inputs; on the cycle after rst: out_valid=0, out_instr=0, out_addr=0, counter=0, err=0, err_cnt=0, wrapped=0.
REQ-036 rst asserted while FULL discards the held word; the word is not delivered.
REQ-037 in_ready=0 while rst=1.

Verification
REQ-038 R: fmt=00, opcode=0x33, funct7=0, rs2=2, rs1=1, funct3=0, rd=3 -> next cycle out_instr=0x002081B3, out_addr=0.
REQ-039 I: fmt=01, opcode=0x13, imm=0x00FFF, rs1=0, funct3=0, rd=5 -> out_instr=0xFFF00293, out_addr=1.
REQ-040 U: fmt=10, opcode=0x37, imm=0x12345, rd=1 -> out_instr=0x123450B7.
REQ-041 Backpressure: out_ready=0 for 3 cycles while FULL -> out_instr/out_addr unchanged, in_ready=0; out_ready=1 -> word taken, in_ready=1 same cycle.
REQ-042 Illegal: fmt=00 with opcode=0x13 -> out_valid stays 0, err pulses 1 cycle, err_cnt=1, next legal word keeps the unadvanced address.
REQ-043 Wrap: IMEM_AW=2, five legal words, out_ready=1 -> addresses 0,1,2,3,0, wrapped=1 after fourth; then addr_clr with accept -> address 0.
